dda_stream_packer: RTL and testbench
====================================

DDA_STREAM_PACKER -- requirements
Module: dda_stream_packer

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 320, the number of rays per frame (hcount range 0..SCREEN_WIDTH-1).
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 180, the line-height clamp value.
REQ-003 SHALL have parameter DEPTH, default 4, the buffer entry count; legal values are powers of two, 2..16.
REQ-004 SHALL have one clock, pixel_clk_in; reset is synchronous and active-high: rst_in.
REQ-005 pixel_clk_in  input  1  clock for all logic.
REQ-006 rst_in  input  1  synchronous active-high reset.
REQ-007 valid_in  input  1  DDA result valid this cycle; single-cycle strobe; no backpressure from the DDA.
REQ-008 hcount_ray_in  input  9  screen column of the result.
REQ-009 lineHeight_in  input  16  unclamped line height.
REQ-010 wallType_in  input  1  0 = X wall, 1 = Y wall.
REQ-011 mapData_in  input  4  map cell value.
REQ-012 wallX_in  input  16  wall hit position.
REQ-013 dda_fifo_tready_in  input  1  downstream accepts the word.
REQ-014 dda_fifo_tvalid_out  output  1  a word is presented.
REQ-015 dda_fifo_tdata_out  output  38  packed word.
REQ-016 dda_fifo_tlast_out  output  1  the word is the last column of the frame.
REQ-017 dda_ready_out  output  1  buffer not full; the upstream throttle hint.
REQ-018 overflow_out  output  1  sticky flag: a result was dropped.
REQ-019 seq_error_out  output  1  sticky flag: a column arrived out of order.
REQ-020 frame_done_out  output  1  one-cycle pulse when the tlast word handshakes.

Function
REQ-021 Packing SHALL be: [37:29] hcount_ray_in, [28:21] clamped height, [20] wallType_in, [19:16] mapData_in, [15:0] wallX_in.
REQ-022 Clamped height SHALL be min(lineHeight_in, SCREEN_HEIGHT), truncated to 8 bits only after clamping.
REQ-023 tlast SHALL be computed at write time as (hcount_ray_in == SCREEN_WIDTH-1) and stored with the entry.
REQ-024 The buffer SHALL be a circular FIFO with first-word-fall-through behaviour, using read pointer, write pointer and an occupancy count of 0..DEPTH.
REQ-025 Push rule: valid_in with count < DEPTH (count sampled before this edge) SHALL write the entry and advance the write pointer, wrapping DEPTH-1 to 0.
REQ-026 Drop rule: valid_in with count == DEPTH SHALL drop the input and set overflow_out, even if a pop occurs in the same cycle.
REQ-027 Pop rule: dda_fifo_tvalid_out && dda_fifo_tready_in SHALL advance the read pointer, wrapping DEPTH-1 to 0.
REQ-028 A push and pop in the same cycle SHALL leave count unchanged.
REQ-029 dda_fifo_tvalid_out SHALL equal (count != 0), driven from registered state.
REQ-030 dda_fifo_tdata_out and dda_fifo_tlast_out SHALL show the head entry when tvalid is high, and zeros when tvalid is low.
REQ-031 Latency: input accepted at edge N into an empty buffer SHALL be presented with tvalid=1 in the cycle after edge N.
REQ-032 Once tvalid is high, tdata and tlast SHALL stay stable until the handshake completes.
REQ-033 dda_ready_out SHALL equal (count < DEPTH).
REQ-034 Sequence checker: expected column register exp_h, reset 0.
REQ-035 On each accepted push, hcount_ray_in != exp_h SHALL set seq_error_out.
REQ-036 On each accepted push, exp_h SHALL become (hcount_ray_in == SCREEN_WIDTH-1) ? 0 : hcount_ray_in+1, resynchronising on the received value.
REQ-037 Dropped inputs SHALL NOT update exp_h.
REQ-038 frame_done_out SHALL be registered high for exactly one cycle after the edge where a tlast=1 word handshakes.
REQ-039 overflow_out and seq_error_out SHALL clear only on rst_in.

Reset
REQ-040 When rst_in is high at an edge, the block SHALL set pointers, count, exp_h, overflow_out, seq_error_out and frame_done_out to 0.
REQ-041 After reset, dda_fifo_tvalid_out, tdata and tlast SHALL be 0, and dda_ready_out SHALL be 1.
REQ-042 rst_in SHALL take priority over a simultaneous push or pop.
REQ-043 Reset mid-stream SHALL discard all buffered entries with no handshake completing.
REQ-044 The contents of buffer storage are unspecified after reset and SHALL never be visible at the outputs.

Verification
REQ-045 Single push: valid_in, hcount=5, lineHeight=100, wallType=1, mapData=1, wallX=0x1234, tready=1 -> next cycle tvalid=1, tdata={9'd5,8'd100,1,4'd1,16'h1234}, tlast=0, seq_error set (exp_h=0).
REQ-046 Clamp: lineHeight=0x0400 -> tdata[28:21]=180; lineHeight=179 -> 179.
REQ-047 Overflow: tready=0, 5 consecutive pushes with DEPTH=4 -> dda_ready_out=0 after the 4th, overflow_out=1 after the 5th; tready=1 then drains exactly 4 words in order.
REQ-048 Frame: 320 in-order pushes hcount 0..319, tready toggling 50% -> 320 words in order, tlast only on hcount 319, one frame_done_out pulse, seq_error_out=0.
REQ-049 Full plus simultaneous pop: count=4, tready=1, valid_in=1 -> input dropped, overflow set, count becomes 3.
REQ-050 Reset mid-stream: 3 words buffered, rst_in for 1 cycle -> tvalid=0, dda_ready_out=1, flags 0; the next push of hcount 0 gives seq_error_out=0.

Source files
------------

// File: rtl/dda_stream_packer.sv
// dda_stream_packer
// Packs per-column DDA results into 38-bit words and buffers them in a small
// first-word-fall-through FIFO towards an AXI-Stream style consumer. Also
// tracks column ordering, dropped results and end-of-frame handshakes.
module dda_stream_packer #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int DEPTH         = 4
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [8:0]  hcount_ray_in,
    input  logic [15:0] lineHeight_in,
    input  logic        wallType_in,
    input  logic [3:0]  mapData_in,
    input  logic [15:0] wallX_in,
    input  logic        dda_fifo_tready_in,
    output logic        dda_fifo_tvalid_out,
    output logic [37:0] dda_fifo_tdata_out,
    output logic        dda_fifo_tlast_out,
    output logic        dda_ready_out,
    output logic        overflow_out,
    output logic        seq_error_out,
    output logic        frame_done_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_MAX    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [8:0]       LAST_COL   = 9'(SCREEN_WIDTH - 1);
    localparam logic [15:0]      HEIGHT_MAX = 16'(SCREEN_HEIGHT);

    // Clamp first, narrow afterwards, so tall walls saturate instead of wrapping.
    function automatic logic [7:0] clamp_height(input logic [15:0] lh);
        logic [15:0] c;
        if (lh > HEIGHT_MAX) begin
            c = HEIGHT_MAX;
        end else begin
            c = lh;
        end
        return c[7:0];
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_MAX) begin
            n = '0;
        end else begin
            n = p + PTR_ONE;
        end
        return n;
    endfunction

    // Entry layout: bit 38 is the stored tlast, bits 37:0 the packed word.
    logic [38:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [8:0]       exp_h_r;
    logic             overflow_r;
    logic             seq_error_r;
    logic             frame_done_r;

    logic             push_s;
    logic             drop_s;
    logic             pop_s;
    logic             not_empty_s;
    logic [38:0]      head_s;
    logic [38:0]      entry_s;
    logic [8:0]       exp_h_next_s;

    // Handshake decode and entry formation for the current cycle.
    always_comb begin
        not_empty_s  = (count_r != '0);
        head_s       = mem_r[rd_ptr_r];
        push_s       = valid_in && (count_r != CNT_FULL);
        drop_s       = valid_in && (count_r == CNT_FULL);
        pop_s        = not_empty_s && dda_fifo_tready_in;
        entry_s      = {(hcount_ray_in == LAST_COL), hcount_ray_in,
                        clamp_height(lineHeight_in), wallType_in,
                        mapData_in, wallX_in};
        if (hcount_ray_in == LAST_COL) begin
            exp_h_next_s = 9'd0;
        end else begin
            exp_h_next_s = hcount_ray_in + 9'd1;
        end
    end

    // Buffer storage; contents are never shown while the FIFO is empty, so no reset.
    always_ff @(posedge pixel_clk_in) begin
        if (push_s && !rst_in) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Pointers, occupancy, sequence tracking and sticky status flags.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            exp_h_r      <= 9'd0;
            overflow_r   <= 1'b0;
            seq_error_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
                exp_h_r  <= exp_h_next_s;
                if (hcount_ray_in != exp_h_r) begin
                    seq_error_r <= 1'b1;
                end
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            frame_done_r <= pop_s && head_s[38];
        end
    end

    assign dda_fifo_tvalid_out = not_empty_s;
    assign dda_fifo_tdata_out  = not_empty_s ? head_s[37:0] : 38'd0;
    assign dda_fifo_tlast_out  = not_empty_s ? head_s[38] : 1'b0;
    assign dda_ready_out       = (count_r != CNT_FULL);
    assign overflow_out        = overflow_r;
    assign seq_error_out       = seq_error_r;
    assign frame_done_out      = frame_done_r;

endmodule

// File: tb/tb_dda_stream_packer.sv
// Testbench for dda_stream_packer: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model of the packer.
module tb_dda_stream_packer;

    localparam int SW    = 320;
    localparam int SH    = 180;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [8:0]  hcount;
    logic [15:0] lheight;
    logic        wtype;
    logic [3:0]  mdata;
    logic [15:0] wallx;
    logic        tready;
    logic        tvalid;
    logic [37:0] tdata;
    logic        tlast;
    logic        rdy;
    logic        ovf;
    logic        seqerr;
    logic        fdone;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [38:0] mq[$];
    int          m_exp;
    logic        m_ovf;
    logic        m_seq;
    logic        m_fd;

    // Logs of observed handshakes
    int          log_h[$];
    logic        log_last[$];
    int          fd_cnt;

    dda_stream_packer #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .DEPTH(DEPTH)) dut (
        .pixel_clk_in        (clk),
        .rst_in              (rst),
        .valid_in            (valid),
        .hcount_ray_in       (hcount),
        .lineHeight_in       (lheight),
        .wallType_in         (wtype),
        .mapData_in          (mdata),
        .wallX_in            (wallx),
        .dda_fifo_tready_in  (tready),
        .dda_fifo_tvalid_out (tvalid),
        .dda_fifo_tdata_out  (tdata),
        .dda_fifo_tlast_out  (tlast),
        .dda_ready_out       (rdy),
        .overflow_out        (ovf),
        .seq_error_out       (seqerr),
        .frame_done_out      (fdone)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [38:0] ref_entry(input int h, input int lh, input logic wt,
                                              input logic [3:0] md, input logic [15:0] wx);
        int          clamped;
        logic [7:0]  h8;
        logic [8:0]  h9;
        clamped = (lh < SH) ? lh : SH;
        h8 = 8'(clamped);
        h9 = 9'(h);
        return {(h == SW - 1), h9, h8, wt, md, wx};
    endfunction

    // Compare outputs with the model, advance the model across one clock edge.
    task automatic tick();
        logic        mv;
        logic [38:0] head;
        logic        do_pop;
        logic        do_push;
        mv   = (mq.size() != 0);
        head = mv ? mq[0] : 39'd0;
        check_eq("tvalid", tvalid, mv);
        check_eq("tdata", tdata, head[37:0]);
        check_eq("tlast", tlast, head[38]);
        check_eq("ready", rdy, mq.size() < DEPTH);
        check_eq("overflow", ovf, m_ovf);
        check_eq("seq_error", seqerr, m_seq);
        check_eq("frame_done", fdone, m_fd);
        if (tvalid && tready) begin
            log_h.push_back(int'(tdata[37:29]));
            log_last.push_back(tlast);
        end
        if (fdone) fd_cnt++;
        if (rst) begin
            mq.delete();
            m_exp = 0;
            m_ovf = 1'b0;
            m_seq = 1'b0;
            m_fd  = 1'b0;
        end else begin
            do_pop  = mv && tready;
            do_push = valid && (mq.size() < DEPTH);
            m_fd    = do_pop && head[38];
            if (valid && !do_push) m_ovf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(ref_entry(int'(hcount), int'(lheight), wtype, mdata, wallx));
                if (int'(hcount) != m_exp) m_seq = 1'b1;
                m_exp = (int'(hcount) == SW - 1) ? 0 : int'(hcount) + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_push(input int h, input int lh);
        valid   = 1'b1;
        hcount  = 9'(h);
        lheight = 16'(lh);
        wtype   = 1'($urandom_range(0, 1));
        mdata   = 4'($urandom_range(0, 15));
        wallx   = 16'($urandom_range(0, 65535));
    endtask

    // Drain with tready high; returns number of words handshaken.
    task automatic drain(output int n);
        n = 0;
        tready = 1'b1;
        valid  = 1'b0;
        for (int i = 0; i < 50 && tvalid; i++) begin
            n++;
            tick();
        end
    endtask

    initial begin
        logic [37:0] exp45;
        int          n;
        int          waits;
        rst = 1'b1; valid = 1'b0; hcount = 9'd0; lheight = 16'd0; wtype = 1'b0;
        mdata = 4'd0; wallx = 16'd0; tready = 1'b0;
        mq.delete(); m_exp = 0; m_ovf = 1'b0; m_seq = 1'b0; m_fd = 1'b0; fd_cnt = 0;
        @(posedge clk);
        #1;
        do_reset();
        check_eq("rst_tvalid", tvalid, 1'b0);
        check_eq("rst_ready", rdy, 1'b1);
        check_eq("rst_tdata", tdata, 38'd0);

        // Single push with known fields
        tready = 1'b1;
        valid = 1'b1; hcount = 9'd5; lheight = 16'd100; wtype = 1'b1; mdata = 4'd1; wallx = 16'h1234;
        tick();
        valid = 1'b0;
        exp45 = {9'd5, 8'd100, 1'b1, 4'd1, 16'h1234};
        check_eq("single_tvalid", tvalid, 1'b1);
        check_eq("single_tdata", tdata, exp45);
        check_eq("single_tlast", tlast, 1'b0);
        check_eq("single_seqerr", seqerr, 1'b1);
        tick();

        // Clamp boundaries
        set_push(6, 16'h0400);
        tick();
        valid = 1'b0;
        check_eq("clamp_big", tdata[28:21], 8'd180);
        set_push(7, 179);
        tick();
        valid = 1'b0;
        check_eq("clamp_179", tdata[28:21], 8'd179);
        set_push(8, 180);
        tick();
        valid = 1'b0;
        check_eq("clamp_180", tdata[28:21], 8'd180);
        tick();

        // Overflow with a stalled consumer
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_push(i, $urandom_range(0, 400));
            tick();
            if (i == 3) check_eq("ovf_ready_after4", rdy, 1'b0);
            if (i == 4) check_eq("ovf_flag_after5", ovf, 1'b1);
        end
        log_h.delete(); log_last.delete();
        drain(n);
        check_eq("ovf_drain_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_h.size()) check_eq("ovf_drain_order", log_h[i], i);
        end

        // Full FIFO with a simultaneous pop: input still dropped
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_push(i, 50);
            tick();
        end
        tready = 1'b1;
        set_push(4, 50);
        tick();
        valid = 1'b0;
        tready = 1'b0;
        check_eq("fullpop_ovf", ovf, 1'b1);
        check_eq("fullpop_ready", rdy, 1'b1);
        check_eq("fullpop_head", tdata[37:29], 9'd1);
        drain(n);
        check_eq("fullpop_count", n, 3);

        // Reset in the middle of a stream
        do_reset();
        tready = 1'b0;
        set_push(0, 10); tick();
        set_push(1, 10); tick();
        set_push(7, 10); tick();
        valid = 1'b0;
        check_eq("mid_seq_before", seqerr, 1'b1);
        do_reset();
        check_eq("mid_tvalid", tvalid, 1'b0);
        check_eq("mid_ready", rdy, 1'b1);
        check_eq("mid_ovf", ovf, 1'b0);
        check_eq("mid_seq", seqerr, 1'b0);
        set_push(0, 10); tick();
        valid = 1'b0;
        check_eq("mid_seq_after_push", seqerr, 1'b0);
        drain(n);
        check_eq("mid_drain", n, 1);

        // Full frame with a 50% consumer, producer throttled by the ready hint
        do_reset();
        log_h.delete(); log_last.delete(); fd_cnt = 0;
        for (int h = 0; h < SW; h++) begin
            valid = 1'b0;
            waits = 0;
            while (!rdy && waits < 100) begin
                tready = 1'($urandom_range(0, 1));
                tick();
                waits++;
            end
            if (waits >= 100) check_eq("frame_wait_timeout", 1'b1, 1'b0);
            set_push(h, $urandom_range(0, 300));
            tready = 1'($urandom_range(0, 1));
            tick();
        end
        valid = 1'b0;
        for (int i = 0; i < 200 && (tvalid || fdone); i++) begin
            tready = 1'($urandom_range(0, 1));
            tick();
        end
        tready = 1'b0;
        tick();
        check_eq("frame_words", log_h.size(), SW);
        n = 0;
        for (int i = 0; i < log_h.size(); i++) begin
            if (log_h[i] != i || log_last[i] != (i == SW - 1)) n++;
        end
        check_eq("frame_order_errs", n, 0);
        check_eq("frame_done_pulses", fd_cnt, 1);
        check_eq("frame_seqerr", seqerr, 1'b0);
        check_eq("frame_ovf", ovf, 1'b0);

        // Randomized traffic, checked every cycle by the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
            valid = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 15) == 0) begin
                hcount = 9'($urandom_range(0, SW - 1));
            end else begin
                hcount = 9'(m_exp);
            end
            case ($urandom_range(0, 2))
                0: lheight = 16'($urandom_range(170, 190));
                1: lheight = 16'($urandom_range(0, 65535));
                default: lheight = 16'($urandom_range(0, 255));
            endcase
            wtype  = 1'($urandom_range(0, 1));
            mdata  = 4'($urandom_range(0, 15));
            wallx  = 16'($urandom_range(0, 65535));
            tready = ($urandom_range(0, 9) < 5);
            tick();
        end
        rst = 1'b0;
        valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
